spi_slave: RTL and testbench
============================

# spi_slave

SPI slave endpoint that sits directly downstream of the `spi` master, on the far end of its `ss`/`sclk`/`mosi`/`miso` wires. It oversamples the SPI pins in the system clock domain and supports all four CPOL/CPHA modes, selected by the same 2-bit `mode` encoding as the master. Each received byte is presented as a parallel word with a one-cycle valid strobe. Transmit bytes are accepted through a single-entry holding register, so the serial-bench echo slave becomes synthesizable RTL.

## Interface
- No parameters; data width fixed at 8, MSB first.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode` in 2: {CPOL, CPHA}. Sampled only while `ss`=1; changes during a transfer are ignored until `ss` rises.
- `ss` in 1: slave select from the master, active low, asynchronous to `clk`.
- `sclk` in 1: serial clock from the master, asynchronous to `clk`.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master; driven 0 when `ss`=1.
- `tx_data` in 8: byte to transmit.
- `tx_load` in 1: writes `tx_data` into the holding register when `tx_empty`=1; ignored otherwise.
- `tx_empty` out 1: holding register is free.
- `tx_urun` out 1: one-cycle pulse; a byte started with the holding register empty, so 0x00 is sent.
- `rx_data` out 8: last complete received byte; holds until the next byte completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while `ss` (synchronized) is low.

## Operation
- Input synchronization:
  - `ss`, `sclk` and `mosi` each pass through a 2-flop synchronizer.
  - `sclk` edges are detected by comparing the synchronized value with a third flop.
  - The `mosi` sample is taken from the synchronized stream in the same cycle the edge is detected.
- Edge roles, with CPOL = `mode[1]`, CPHA = `mode[0]`:
  - Leading edge is rising if CPOL=0 and falling if CPOL=1.
  - CPHA=0: sample on the leading edge; shift `miso` on the trailing edge.
  - CPHA=1: shift `miso` on the leading edge; sample on the trailing edge.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: `ss`=1; `miso`=0; bit counter = 0; `mode` is latched each cycle. Synchronized `ss` falling -> LOAD.
  - LOAD (one cycle):
    - Copy the holding register into the tx shift register and set `tx_empty`=1.
    - If the holding register was empty, load 0x00 and pulse `tx_urun`.
    - CPHA=0: drive `miso` = shift[7] immediately.
    - Go to SHIFT.
  - SHIFT:
    - On each sample edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt += 1.
    - On each shift edge: for CPHA=0, shift left and drive the new bit 7; for CPHA=1, drive shift[7] and then shift left.
    - When bit_cnt wraps 7 -> 0 on a sample edge: `rx_data` <= the completed byte and `rx_valid` pulses.
    - CPHA=0: the next trailing edge reloads the tx shift register from the holding register (same underrun rule) instead of shifting, and drives the new bit 7.
    - CPHA=1: the reload happens on the next leading edge, before that edge drives `miso`.
  - `ss` rises (synchronized) in any state -> IDLE. A partial byte is discarded with no `rx_valid`; bit_cnt = 0; `miso` = 0.
- Holding register:
  - `tx_load` when `tx_empty`=1 sets `tx_empty`=0 the next cycle.
  - If `tx_load` coincides with a reload, the reload takes the old (empty) state, so the underrun is reported, and the new byte is kept for the following byte.

## Timing
- Reset values: `miso`=0, `tx_empty`=1, `tx_urun`=0, `rx_data`=0x00, `rx_valid`=0, `busy`=0, FSM=IDLE, all shift registers and counters 0.
- Reset asserted mid-transfer aborts immediately. After `rst_n` rises, the block waits in IDLE for the next `ss` falling edge, even if `ss` is already low.
- Pin-to-detect latency is 3 `clk` cycles (2 synchronizer stages + edge flop).
- `rx_valid` is asserted on the cycle after the 8th sample edge is detected, i.e. 4 cycles after the pin edge.
- `miso` updates 4 cycles after the pin shift edge.
- Constraints on the master:
  - `sclk` half-period ≥ 6 `clk` cycles.
  - `ss` falling edge to first `sclk` edge ≥ 6 cycles.
  - Last `sclk` edge to `ss` rising edge ≥ 6 cycles.
- `tx_empty` rises in LOAD or at a reload. Software has ≥ 7 `sclk` half-periods to load the next byte.

## Test plan
- Mode 00, master sends 0xA5 with `tx_data`=0x3C preloaded -> `rx_data`=0xA5 with exactly one `rx_valid` pulse; master receives 0x3C; `tx_urun` never pulses.
- Repeat the previous scenario for modes 01, 10 and 11 -> identical bytes in both directions; `miso` stable across every master sample edge.
- Master sends 32 bytes (90, 12, 33 … 167) back-to-back under one `ss`, with the bench reloading each received byte through `tx_load` on `rx_valid` -> 32 `rx_valid` pulses in order; master reads the echo of byte n-1 during byte n; first echoed byte is 0x00 with one `tx_urun`.
- `ss` rises after 5 bits of 0xFF -> no `rx_valid`; `rx_data` unchanged; next full byte 0x81 is received correctly.
- `tx_load` with 0x11 then 0x22 while `tx_empty`=0 -> 0x22 is ignored; master receives 0x11.
- `rst_n` pulsed low mid-byte -> all outputs return to reset values within one cycle; no spurious `rx_valid`; the next `ss` cycle transfers 0x5A correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave supporting all four CPOL/CPHA modes,
// with a parallel receive port and a single-entry transmit holding register.
module spi_slave (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       ss,
    input  logic       sclk,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       tx_urun,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state, state_nx;
    logic [1:0] ss_s, sclk_s, mosi_s, mode_q;
    logic       ss_d, sclk_d, reload_pend;
    logic [7:0] tx_shift, hold, next_byte, tx_src, cpha0_next, rx_next;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       rise, fall, lead, trail, abort, in_load, sample_e, shift_e, reload;

    assign rise       = sclk_s[1] & ~sclk_d;
    assign fall       = ~sclk_s[1] & sclk_d;
    assign lead       = mode_q[1] ? fall : rise;
    assign trail      = mode_q[1] ? rise : fall;
    assign abort      = (state != IDLE) && ss_s[1];
    assign in_load    = (state == LOAD) && !ss_s[1];
    assign sample_e   = (state == SHIFT) && !ss_s[1] && (mode_q[0] ? trail : lead);
    assign shift_e    = (state == SHIFT) && !ss_s[1] && (mode_q[0] ? lead : trail);
    assign reload     = in_load || (shift_e && reload_pend);
    assign next_byte  = tx_empty ? 8'h00 : hold;
    assign tx_src     = reload_pend ? next_byte : tx_shift;
    assign cpha0_next = reload_pend ? next_byte : {tx_shift[6:0], 1'b0};
    assign rx_next    = {rx_shift, mosi_s[1]};
    assign busy       = state != IDLE;

    // ss_d resets low so a select already held low after reset is not seen as a new falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_s   <= '0;
            sclk_s <= '0;
            mosi_s <= '0;
            ss_d   <= 1'b0;
            sclk_d <= 1'b0;
        end else begin
            ss_s   <= {ss_s[0], ss};
            sclk_s <= {sclk_s[0], sclk};
            mosi_s <= {mosi_s[0], mosi};
            ss_d   <= ss_s[1];
            sclk_d <= sclk_s[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort)                          state_nx = IDLE;
        else if (state == IDLE && ss_d && !ss_s[1]) state_nx = LOAD;
        else if (state == LOAD)             state_nx = SHIFT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            hold        <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            miso        <= 1'b0;
            tx_empty    <= 1'b1;
            tx_urun     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
        end else begin
            tx_urun  <= reload && tx_empty;
            rx_valid <= 1'b0;
            // a load landing on a reload survives for the byte after
            if (reload) tx_empty <= 1'b1;
            if (tx_load && tx_empty) begin
                hold     <= tx_data;
                tx_empty <= 1'b0;
            end
            if (state == IDLE) mode_q <= mode;
            if (state == IDLE || abort) begin
                miso        <= 1'b0;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (in_load) begin
                tx_shift <= next_byte;
                if (!mode_q[0]) miso <= next_byte[7];
            end
            if (shift_e) begin
                reload_pend <= 1'b0;
                tx_shift    <= mode_q[0] ? {tx_src[6:0], 1'b0} : cpha0_next;
                miso        <= mode_q[0] ? tx_src[7] : cpha0_next[7];
            end
            if (sample_e) begin
                rx_shift <= rx_next[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data     <= rx_next;
                    rx_valid    <= 1'b1;
                    reload_pend <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master driving spi_slave, checked against a byte-level
// model of the holding register and the expected receive stream.
module tb_spi_slave;
    localparam int H = 8;
    logic       clk, rst_n, ss, sclk, mosi, miso, tx_load, tx_empty, tx_urun, rx_valid, busy;
    logic [1:0] mode, cur_mode;
    logic [7:0] tx_data, rx_data, got, ld_byte, last_rx, mdl_hold;
    logic [7:0] exp_rx[$];
    logic [7:0] echo_b[32];
    logic       mdl_empty, echo_en, last_full;
    int         checks, failures, urun_cnt, exp_urun, ld_cnt, ld_seen, ss_hi;

    spi_slave dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ss(ss), .sclk(sclk), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty),
        .tx_urun(tx_urun), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mdl_load(input logic [7:0] b);
        if (mdl_empty) begin
            mdl_hold  = b;
            mdl_empty = 1'b0;
        end
    endtask

    task automatic mdl_take(output logic [7:0] b);
        if (mdl_empty) begin
            b = 8'h00;
            exp_urun++;
        end else begin
            b = mdl_hold;
            mdl_empty = 1'b1;
        end
    endtask

    task automatic do_load(input logic [7:0] b);
        ld_byte = b;
        ld_cnt++;
        wait_clk(3);
    endtask

    task automatic set_mode(input logic [1:0] m);
        cur_mode = m;
        mode = m;
        sclk = m[1];
        wait_clk(6);
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        wait_clk(6);
    endtask

    task automatic ss_end();
        logic [7:0] d;
        if (last_full && !cur_mode[0]) mdl_take(d);
        wait_clk(H);
        ss = 1'b1;
        wait_clk(H);
        chk("urun_count", urun_cnt, exp_urun);
        chk("rx_all_seen", exp_rx.size(), 0);
    endtask

    // master side of one byte (or a truncated one); miso must hold for 3 cycles up to each sample edge
    task automatic xfer_byte(input logic [7:0] mo, input int nbits, output logic [7:0] r);
        logic [7:0] exp_tx;
        logic m0, m1;
        mdl_take(exp_tx);
        if (nbits == 8) exp_rx.push_back(mo);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (cur_mode[0]) sclk = ~cur_mode[1];
            mosi = mo[7-i];
            wait_clk(H - 3);
            m0 = miso;
            wait_clk(3);
            m1 = miso;
            sclk = cur_mode[0] ? cur_mode[1] : ~cur_mode[1];
            chk("miso_stable", m1, m0);
            r[7-i] = m1;
            wait_clk(H);
            if (!cur_mode[0]) sclk = cur_mode[1];
        end
        last_full = (nbits == 8);
        if (nbits == 8) chk("master_rx", r, exp_tx);
    endtask

    // compare process: receive stream, rx_data hold, underrun count, idle pins; also owns tx_load
    initial begin
        logic [7:0] e;
        tx_load = 1'b0;
        tx_data = 8'h00;
        forever begin
            @(negedge clk);
            tx_load = 1'b0;
            ss_hi = ss ? ss_hi + 1 : 0;
            if (rst_n) begin
                if (tx_urun) urun_cnt++;
                if (rx_valid) begin
                    if (exp_rx.size() == 0) chk("rx_spurious", rx_valid, 0);
                    else begin
                        e = exp_rx.pop_front();
                        chk("rx_data", rx_data, e);
                        last_rx = e;
                        if (echo_en) begin
                            tx_data = e;
                            tx_load = 1'b1;
                            mdl_load(e);
                        end
                    end
                end else chk("rx_hold", rx_data, last_rx);
                if (ss_hi >= 6) begin
                    chk("idle_miso", miso, 0);
                    chk("idle_busy", busy, 0);
                end
            end
            if (ld_seen != ld_cnt) begin
                ld_seen = ld_cnt;
                tx_data = ld_byte;
                tx_load = 1'b1;
                mdl_load(ld_byte);
            end
        end
    end

    initial begin
        checks = 0; failures = 0; urun_cnt = 0; exp_urun = 0; ld_cnt = 0; ld_seen = 0; ss_hi = 0;
        mdl_empty = 1'b1; mdl_hold = 8'h00; last_rx = 8'h00; echo_en = 1'b0; last_full = 1'b0;
        rst_n = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'b00; cur_mode = 2'b00;
        for (int i = 0; i < 32; i++)
            echo_b[i] = (i == 0) ? 8'd90 : (i == 1) ? 8'd12 : (i == 2) ? 8'd33 :
                        (i == 31) ? 8'd167 : 8'((i * 53 + 17) % 256);
        wait_clk(3);
        chk("rst_miso", miso, 0);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_tx_urun", tx_urun, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        wait_clk(4);

        for (int m = 0; m < 4; m++) begin
            set_mode(2'(m));
            do_load(8'h3C);
            ss_begin();
            xfer_byte(8'hA5, 8, got);
            chk("mode_tx_3c", got, 8'h3C);
            ss_end();
            chk("mode_rx_a5", rx_data, 8'hA5);
        end

        set_mode(2'b00);
        echo_en = 1'b1;
        ss_begin();
        for (int i = 0; i < 32; i++) begin
            xfer_byte(echo_b[i], 8, got);
            if (i == 0) chk("echo_first_00", got, 8'h00);
            if (i == 1) chk("echo_second_90", got, 8'd90);
        end
        ss_end();
        echo_en = 1'b0;

        ss_begin();
        xfer_byte(8'hFF, 5, got);
        ss_end();
        chk("partial_rx_kept", rx_data, 8'hA7);
        ss_begin();
        xfer_byte(8'h81, 8, got);
        ss_end();
        chk("after_partial_81", rx_data, 8'h81);

        set_mode(2'b01);
        do_load(8'h11);
        chk("load_fills", tx_empty, 0);
        do_load(8'h22);
        ss_begin();
        xfer_byte(8'hE7, 8, got);
        chk("ignored_load_11", got, 8'h11);
        ss_end();
        chk("hold_freed", tx_empty, 1);

        set_mode(2'b00);
        do_load(8'h96);
        ss_begin();
        xfer_byte(8'h33, 4, got);
        @(negedge clk);
        #2 rst_n = 1'b0;
        mdl_empty = 1'b1;
        last_rx = 8'h00;
        #1;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_tx_empty", tx_empty, 1);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_rx_valid", rx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(10);
        chk("rst_waits_for_ss", busy, 0);
        ss = 1'b1;
        wait_clk(8);
        do_load(8'hC3);
        ss_begin();
        xfer_byte(8'h5A, 8, got);
        chk("post_rst_tx_c3", got, 8'hC3);
        ss_end();
        chk("post_rst_rx_5a", rx_data, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
